ps_irq_ctrl: RTL and testbench
==============================

// Module: ps_irq_ctrl
// PURPOSE
//  Interrupt controller for the program sequencer. Latches edge-triggered sources into IRPTL,
//  masks with IMASK/GIE, arbitrates by fixed priority against the in-service set (IMASKP),
//  and hands one vector at a time to the PS over a req/ack handshake. Drives the PS wake input
//  and services RTI. Sits beside the PS; its registers live in the PS ureg space.
// PARAMETERS
//  N_IRQ      4       interrupt sources, 1..15; bit 0 = highest priority
//  VEC_BASE   16'h0040 vector address of source 0
//  VEC_STRIDE 16'h0004 address step between consecutive vectors
//  GUARD_CYC  2       cycles after ack before a new request may assert (covers PS jump delay slots)
// PORTS
//  clk          in  1      clock
//  rst          in  1      reset, asynchronous, active-low
//  irq_in       in  N_IRQ  synchronous source lines, rising-edge sensitive
//  ic_wrt_en    in  1      ureg write strobe
//  ic_wrt_add   in  5      ureg write address
//  ic_wrt_dt    in  16     ureg write data
//  ic_rd_add    in  5      ureg read address
//  ic_rd_dt     out 16     read data, combinational; 0 on unmapped address
//  ps_ic_ack    in  1      1-cycle pulse: PS took the vector and pushed the return address
//  ps_ic_rti    in  1      1-cycle pulse: PS executed RTI
//  ic_ps_req    out 1      interrupt request, level, held until ack or cancel
//  ic_ps_vec    out 16     vector address, stable while ic_ps_req=1
//  ic_ps_wake   out 1      any pending & unmasked source (ignores GIE); drives PS idle exit
// BEHAVIOUR
//  Registers (addr): IRPTL 5'b11000 [N-1:0]; IMASK 5'b11001 [N-1:0], bit15=GIE; IMASKP 5'b11010 [N-1:0] (read-only).
//  Unimplemented bits read 0 and ignore writes. Reads return current register values (no write bypass).
//  Reset: IRPTL=0, IMASK=0 (GIE=0), IMASKP=0, irq_q=0, state=IDLE, guard_cnt=0,
//   ic_ps_req=0, ic_ps_vec=0, ic_ps_wake=0.
//  Edge detect: irq_q<=irq_in; rise=irq_in&~irq_q. rise[i] sets IRPTL[i] at that edge.
//  IRPTL update order per bit: software write, then ack-clear, then rise-set (set wins all).
//  elig = IRPTL & IMASK[N-1:0] & {N{GIE}}; sel = lowest set index of elig; cur = lowest set index of IMASKP.
//  Candidate valid iff elig!=0 and (IMASKP==0 or sel<cur) -> strictly-higher priority nests.
//  FSM (registered):
//   IDLE : candidate valid -> REQ; latch idx=sel, ic_ps_vec=VEC_BASE+sel*VEC_STRIDE (16-bit wrap), req=1.
//   REQ  : ps_ic_ack -> IRPTL[idx]=0, IMASKP[idx]=1, req=0, guard_cnt=GUARD_CYC-1, -> GUARD.
//          else IRPTL[idx] cleared by software write -> req=0, -> IDLE (cancel). Ack same cycle as cancel: ack wins.
//          idx/vec frozen in REQ; higher-priority arrival does not retarget; IMASK/GIE change does not withdraw.
//   GUARD: count down; at 0 -> IDLE. GUARD_CYC=0 -> ack goes straight to IDLE.
//  Latency: irq_in rises before edge k -> IRPTL[i]=1 after k -> ic_ps_req=1 after k+1 (GIE,mask set, IDLE).
//  ic_ps_wake <= |(IRPTL & IMASK[N-1:0]) registered; same timing as req.
//  RTI: clears IMASKP[cur]; IMASKP==0 -> no-op. RTI same cycle as ack: both apply (clear old cur, set idx).
//  ps_ic_ack outside REQ ignored. Async reset mid-handshake returns everything to reset values immediately.
// STRUCTURE
//  Shared package ps_ic_pkg: register address constants (IRPTL/IMASK/IMASKP), GIE bit index, FSM state encoding.
//  Sub-module ic_prio_enc (N-bit lowest-set-bit encoder -> index + valid), instantiated twice (elig, IMASKP).
// TESTING
//  1 Reset, IMASK=16'h8002, pulse irq_in[1] -> IRPTL=2 after edge k, req=1 vec=16'h0044 after k+1; ack -> IRPTL=0, IMASKP=2, req=0.
//  2 In service src2 (IMASKP=4); rise irq_in[0] -> req, vec=16'h0040; rise irq_in[3] -> IRPTL[3]=1, no req until RTI x2.
//  3 GIE=0, IMASK[2]=1, rise irq_in[2] -> wake=1, req=0; write GIE=1 -> req=1 vec=16'h0048 next+1 cycle.
//  4 In REQ for src1, write IRPTL=0 -> req=0 next cycle, state IDLE; repeat with ack same cycle -> IMASKP[1]=1, IRPTL=0.
//  5 Ack src0 with irq_in[0] rising same edge -> IRPTL[0] stays 1; no req during GUARD_CYC=2 cycles; src0 not re-requested (not higher than cur).
//  6 RTI with IMASKP=0 -> no change; async rst asserted while req=1 -> req=0, vec=0, all regs 0 at once.

Source files
------------

// File: rtl/ps_ic_pkg.sv
// Shared definitions for the program-sequencer interrupt controller:
// ureg addresses, GIE position and the request FSM encoding.
package ps_ic_pkg;

    localparam logic [4:0] ADDR_IRPTL  = 5'b11000;
    localparam logic [4:0] ADDR_IMASK  = 5'b11001;
    localparam logic [4:0] ADDR_IMASKP = 5'b11010;

    localparam int unsigned GIE_BIT = 15;
    // Wide enough for up to 15 sources.
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StGuard
    } ic_state_e;

endpackage

// File: rtl/ps_irq_ctrl_if.sv
// Ureg access port plus the request/ack/RTI handshake between the PS (master)
// and the interrupt controller (slave).
interface ps_irq_ctrl_if;

    logic        ic_wrt_en;
    logic [4:0]  ic_wrt_add;
    logic [15:0] ic_wrt_dt;
    logic [4:0]  ic_rd_add;
    logic [15:0] ic_rd_dt;
    logic        ps_ic_ack;
    logic        ps_ic_rti;
    logic        ic_ps_req;
    logic [15:0] ic_ps_vec;
    logic        ic_ps_wake;

    modport master (
        output ic_wrt_en, ic_wrt_add, ic_wrt_dt, ic_rd_add, ps_ic_ack, ps_ic_rti,
        input  ic_rd_dt, ic_ps_req, ic_ps_vec, ic_ps_wake
    );

    modport slave (
        input  ic_wrt_en, ic_wrt_add, ic_wrt_dt, ic_rd_add, ps_ic_ack, ps_ic_rti,
        output ic_rd_dt, ic_ps_req, ic_ps_vec, ic_ps_wake
    );

endinterface

// File: rtl/ic_prio_enc.sv
// Lowest-set-bit encoder: bit 0 is the highest priority.
module ic_prio_enc
    import ps_ic_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]     in_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        idx_o   = '0;
        valid_o = |in_i;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (in_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ps_irq_ctrl.sv
// Interrupt controller: latches source edges into IRPTL, masks, arbitrates against
// the in-service set and hands one vector at a time to the PS.
module ps_irq_ctrl
    import ps_ic_pkg::*;
#(
    parameter int unsigned N_IRQ      = 4,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'h0004,
    parameter int unsigned GUARD_CYC  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    ps_irq_ctrl_if.slave     bus
);

    localparam logic [7:0] GUARD_M1 = (GUARD_CYC == 0) ? 8'd0 : 8'(GUARD_CYC - 1);

    logic [N_IRQ-1:0] irq_q, irptl_q, irptl_d, imask_q, imask_d, imaskp_q, imaskp_d;
    logic [N_IRQ-1:0] rise, elig, idx_oh, cur_oh;
    logic             gie_q, gie_d, wake_q, wake_d, req_q, req_d;
    logic [IDX_W-1:0] idx_q, idx_d, sel_idx, cur_idx;
    logic             sel_vld, cur_vld, cand, took, wr_irptl, wr_imask;
    logic [7:0]       guard_q, guard_d;
    logic [15:0]      vec_q, vec_d;
    ic_state_e        state_q, state_d;
    logic             unused_wdt;

    assign rise     = irq_in & ~irq_q;
    assign elig     = irptl_q & imask_q & {N_IRQ{gie_q}};
    assign wr_irptl = bus.ic_wrt_en && (bus.ic_wrt_add == ADDR_IRPTL);
    assign wr_imask = bus.ic_wrt_en && (bus.ic_wrt_add == ADDR_IMASK);
    assign took     = (state_q == StReq) && bus.ps_ic_ack;
    assign idx_oh   = N_IRQ'(1) << idx_q;
    assign cur_oh   = N_IRQ'(1) << cur_idx;
    // Only a strictly higher priority source may nest over the one in service.
    assign cand     = sel_vld && (!cur_vld || (sel_idx < cur_idx));
    assign unused_wdt = ^bus.ic_wrt_dt;

    ic_prio_enc #(.N(N_IRQ)) u_sel_enc (
        .in_i    (elig),
        .idx_o   (sel_idx),
        .valid_o (sel_vld)
    );

    ic_prio_enc #(.N(N_IRQ)) u_cur_enc (
        .in_i    (imaskp_q),
        .idx_o   (cur_idx),
        .valid_o (cur_vld)
    );

    always_comb begin
        irptl_d = irptl_q;
        if (wr_irptl) irptl_d = bus.ic_wrt_dt[N_IRQ-1:0];
        if (took)     irptl_d = irptl_d & ~idx_oh;
        irptl_d = irptl_d | rise;

        imask_d = imask_q;
        gie_d   = gie_q;
        if (wr_imask) begin
            imask_d = bus.ic_wrt_dt[N_IRQ-1:0];
            gie_d   = bus.ic_wrt_dt[GIE_BIT];
        end

        imaskp_d = imaskp_q;
        if (bus.ps_ic_rti && cur_vld) imaskp_d = imaskp_d & ~cur_oh;
        if (took)                     imaskp_d = imaskp_d | idx_oh;

        wake_d = |(irptl_q & imask_q);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        vec_d   = vec_q;
        req_d   = req_q;
        guard_d = guard_q;
        unique case (state_q)
            StIdle: begin
                if (cand) begin
                    state_d = StReq;
                    idx_d   = sel_idx;
                    vec_d   = VEC_BASE + 16'(sel_idx) * VEC_STRIDE;
                    req_d   = 1'b1;
                end
            end
            StReq: begin
                if (took) begin
                    req_d = 1'b0;
                    if (GUARD_CYC == 0) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StGuard;
                        guard_d = GUARD_M1;
                    end
                end else if ((irptl_d & idx_oh) == '0) begin
                    req_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            StGuard: begin
                if (guard_q == '0) state_d = StIdle;
                else               guard_d = guard_q - 8'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q    <= '0;
            irptl_q  <= '0;
            imask_q  <= '0;
            gie_q    <= 1'b0;
            imaskp_q <= '0;
            wake_q   <= 1'b0;
            state_q  <= StIdle;
            idx_q    <= '0;
            vec_q    <= '0;
            req_q    <= 1'b0;
            guard_q  <= '0;
        end else begin
            irq_q    <= irq_in;
            irptl_q  <= irptl_d;
            imask_q  <= imask_d;
            gie_q    <= gie_d;
            imaskp_q <= imaskp_d;
            wake_q   <= wake_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            vec_q    <= vec_d;
            req_q    <= req_d;
            guard_q  <= guard_d;
        end
    end

    always_comb begin
        bus.ic_rd_dt = '0;
        case (bus.ic_rd_add)
            ADDR_IRPTL:  bus.ic_rd_dt[N_IRQ-1:0] = irptl_q;
            ADDR_IMASK: begin
                bus.ic_rd_dt[N_IRQ-1:0] = imask_q;
                bus.ic_rd_dt[GIE_BIT]   = gie_q;
            end
            ADDR_IMASKP: bus.ic_rd_dt[N_IRQ-1:0] = imaskp_q;
            default:     bus.ic_rd_dt = '0;
        endcase
    end

    assign bus.ic_ps_req  = req_q;
    assign bus.ic_ps_vec  = vec_q;
    assign bus.ic_ps_wake = wake_q;

endmodule

// File: tb/tb_ps_irq_ctrl.sv
// Scoreboard bench for ps_irq_ctrl: a behavioural model queues the expected
// post-edge outputs, a monitor pops and compares them one cycle at a time.
module tb_ps_irq_ctrl;

    localparam int          N     = 4;
    localparam int          GUARD = 2;
    localparam logic [15:0] VBASE = 16'h0040;
    localparam logic [15:0] VSTEP = 16'h0004;
    localparam logic [4:0]  A_PL  = 5'b11000;
    localparam logic [4:0]  A_MSK = 5'b11001;
    localparam logic [4:0]  A_MP  = 5'b11010;

    typedef struct packed {
        logic        req;
        logic [15:0] vec;
        logic        wake;
        logic [4:0]  radd;
        logic [15:0] rd;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] irq_in;
    ps_irq_ctrl_if bus_if ();

    ps_irq_ctrl #(
        .N_IRQ      (N),
        .VEC_BASE   (VBASE),
        .VEC_STRIDE (VSTEP),
        .GUARD_CYC  (GUARD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in),
        .bus    (bus_if.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   rd_rot = 0;

    // Reference state: pending set, enables, in-service set, one outstanding request.
    bit [N-1:0]  m_pend, m_mask, m_insvc, m_prev;
    bit          m_gie, m_req;
    int          m_idx, m_hold;
    logic [15:0] m_vec;
    bit [N-1:0]  irq_v;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lowest(input bit [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] model_rd(input logic [4:0] a);
        logic [15:0] r;
        r = 16'h0000;
        if (a == A_PL) r = 16'(m_pend);
        else if (a == A_MSK) begin
            r = 16'(m_mask);
            r[15] = m_gie;
        end else if (a == A_MP) r = 16'(m_insvc);
        return r;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_insvc = '0; m_prev = '0;
        m_gie = 0; m_req = 0; m_idx = 0; m_hold = 0; m_vec = 16'h0000;
    endtask

    task automatic step(input bit [N-1:0] irq, input bit wen, input logic [4:0] wadd,
                        input logic [15:0] wdt, input bit ack, input bit rti,
                        input logic [4:0] radd);
        bit [N-1:0] elig, npend;
        int sel, cur;
        bit took;
        exp_t e;
        irq_in            = irq;
        bus_if.ic_wrt_en  = wen;
        bus_if.ic_wrt_add = wadd;
        bus_if.ic_wrt_dt  = wdt;
        bus_if.ps_ic_ack  = ack;
        bus_if.ps_ic_rti  = rti;
        bus_if.ic_rd_add  = radd;

        elig   = m_pend & m_mask & {N{m_gie}};
        sel    = lowest(elig);
        cur    = lowest(m_insvc);
        e.wake = |(m_pend & m_mask);
        took   = m_req && ack;

        npend = m_pend;
        if (wen && wadd == A_PL) npend = wdt[N-1:0];
        if (took) npend[m_idx] = 1'b0;
        npend = npend | (irq & ~m_prev);

        if (wen && wadd == A_MSK) begin
            m_mask = wdt[N-1:0];
            m_gie  = wdt[15];
        end
        if (rti && cur >= 0) m_insvc[cur] = 1'b0;
        if (took) m_insvc[m_idx] = 1'b1;

        if (m_req) begin
            if (took) begin
                m_req  = 0;
                m_hold = GUARD;
            end else if (!npend[m_idx]) begin
                m_req = 0;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (sel >= 0 && (cur < 0 || sel < cur)) begin
            m_req = 1;
            m_idx = sel;
            m_vec = VBASE + 16'(sel) * VSTEP;
        end
        m_pend = npend;
        m_prev = irq;

        e.req  = m_req;
        e.vec  = m_vec;
        e.radd = radd;
        e.rd   = model_rd(radd);
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    function automatic logic [4:0] next_radd();
        rd_rot = (rd_rot + 1) % 3;
        return A_PL + 5'(rd_rot);
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(irq_v, 0, 5'd0, 16'h0, 0, 0, next_radd());
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        step(irq_v, 1, a, d, 0, 0, a);
    endtask

    task automatic ack_rti(input bit ack, input bit rti);
        step(irq_v, 0, 5'd0, 16'h0, ack, rti, A_MP);
    endtask

    task automatic async_reset_check();
        rst = 1'b0;
        #1;
        chk("rst_req", 16'(bus_if.ic_ps_req), 16'h0);
        chk("rst_vec", bus_if.ic_ps_vec, 16'h0);
        chk("rst_wake", 16'(bus_if.ic_ps_wake), 16'h0);
        for (int a = 0; a < 3; a++) begin
            bus_if.ic_rd_add = A_PL + 5'(a);
            #1;
            chk("rst_reg", bus_if.ic_rd_dt, 16'h0);
        end
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("req", 16'(bus_if.ic_ps_req), 16'(e.req));
                chk("wake", 16'(bus_if.ic_ps_wake), 16'(e.wake));
                chk($sformatf("rd@%h", e.radd), bus_if.ic_rd_dt, e.rd);
                if (e.req) chk("vec", bus_if.ic_ps_vec, e.vec);
            end
        end
    end

    initial begin : stim
        bit wen, ack, rti;
        logic [4:0] wadd, radd;
        logic [15:0] wdt;
        rst = 1'b0;
        irq_v = '0;
        irq_in = '0;
        bus_if.ic_wrt_en = 0; bus_if.ic_wrt_add = '0; bus_if.ic_wrt_dt = '0;
        bus_if.ic_rd_add = A_PL; bus_if.ps_ic_ack = 0; bus_if.ps_ic_rti = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        async_reset_check();

        // Single source, full handshake.
        wr(A_MSK, 16'h8002);
        irq_v = 4'b0010; idle(1);
        irq_v = 4'b0000; idle(2);
        ack_rti(1, 0); idle(3);
        ack_rti(0, 1); idle(1);

        // Nesting: src0 over src2, src3 blocked until both RTIs.
        wr(A_MSK, 16'h800F);
        irq_v = 4'b0100; idle(2); ack_rti(1, 0); idle(3);
        irq_v = 4'b0101; idle(2); ack_rti(1, 0); idle(3);
        irq_v = 4'b1101; idle(4);
        ack_rti(0, 1); idle(2);
        ack_rti(0, 1); idle(2);
        ack_rti(1, 0); idle(3); ack_rti(0, 1);
        irq_v = 4'b0000; idle(2);

        // GIE off: wake only, then enable.
        wr(A_MSK, 16'h0004);
        irq_v = 4'b0100; idle(3);
        wr(A_MSK, 16'h8004); idle(2);
        ack_rti(1, 0); idle(3); ack_rti(0, 1);
        irq_v = 4'b0000; idle(1);

        // Software cancel, then cancel racing an ack.
        wr(A_MSK, 16'h8002);
        irq_v = 4'b0010; idle(2);
        wr(A_PL, 16'h0000); idle(2);
        irq_v = 4'b0000; idle(1);
        irq_v = 4'b0010; idle(2);
        step(irq_v, 1, A_PL, 16'h0000, 1, 0, A_MP);
        idle(3); ack_rti(0, 1);
        irq_v = 4'b0000; idle(1);

        // Ack with a fresh edge on the same source.
        wr(A_MSK, 16'h8001);
        irq_v = 4'b0001; idle(1);
        irq_v = 4'b0000; idle(1);
        irq_v = 4'b0001; ack_rti(1, 0);
        idle(4);
        ack_rti(0, 1); idle(2);
        ack_rti(1, 0); idle(3); ack_rti(0, 1);
        irq_v = 4'b0000; idle(1);

        // RTI with nothing in service, then reset in mid-request.
        ack_rti(0, 1); idle(1);
        wr(A_MSK, 16'h8002);
        irq_v = 4'b0010; idle(2);
        async_reset_check();
        irq_v = 4'b0000; idle(2);

        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) irq_v = irq_v ^ N'($urandom);
            wen = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 7))
                0, 1:    wadd = A_PL;
                2, 3, 4, 5: wadd = A_MSK;
                6:       wadd = A_MP;
                default: wadd = 5'($urandom);
            endcase
            wdt = 16'($urandom);
            if (wadd == A_MSK) wdt[15] = ($urandom_range(0, 3) != 0);
            ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            rti = ($urandom_range(0, 11) == 0);
            radd = ($urandom_range(0, 5) == 0) ? 5'($urandom) : A_PL + 5'($urandom_range(0, 2));
            step(irq_v, wen, wadd, wdt, ack, rti, radd);
        end

        idle(2);
        @(posedge clk);
        #3;
        chk("sb_drained", 16'(sb.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
